// File: rtl/modcount_sched_pkg.sv
// Shared definitions for the mod-N counter scheduler: FSM state encoding and
// default sizing parameters used by the scheduler and its counter core.
package modcount_sched_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_MOD   = 10;
    localparam int DEF_NREQ  = 2;
    localparam int DEF_LENW  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mod_count_core.sv
// Loadable mod-MOD up-counter; load wins over enable, wraps MOD-1 -> 0.
module mod_count_core #(
    parameter int WIDTH = modcount_sched_pkg::DEF_WIDTH,
    parameter int MOD   = modcount_sched_pkg::DEF_MOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             lde,
    input  logic [WIDTH-1:0] ld,
    output logic [WIDTH-1:0] Q
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            Q <= '0;
        end else if (lde) begin
            Q <= ld;
        end else if (en) begin
            Q <= (Q == LAST) ? '0 : Q + 1'b1;
        end
    end

endmodule

// File: rtl/modcount_sched.sv
// Round-robin scheduler that loads, runs and releases a shared mod-N counter
// on behalf of NREQ requesters.
//
// Handshake: req is a level sampled only in IDLE; the winner sees gnt from
// LOAD through DONE and a one-cycle done pulse in DONE. Inputs are ignored
// outside IDLE, so a granted run always completes unless rst intervenes.
module modcount_sched
    import modcount_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int MOD   = DEF_MOD,
    parameter int NREQ  = DEF_NREQ,
    parameter int LENW  = DEF_LENW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] ld_val,
    input  logic [NREQ*LENW-1:0]  run_len,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  ld_err,
    output logic [WIDTH-1:0]      Q,
    output state_t                o_state
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MOD);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDXW-1:0]   r_last;
    logic [IDXW-1:0]   r_widx;
    logic [WIDTH-1:0]  r_val;
    logic [LENW-1:0]   r_len;
    logic [LENW-1:0]   r_rem;

    logic              w_found;
    logic [IDXW-1:0]   w_win;
    logic              w_lde;
    logic              w_en;
    logic [WIDTH-1:0]  w_ld;
    logic              w_bad;

    // Search starts one past the last winner so a requester that holds req
    // after its done yields to any other pending requester.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && req[(int'(r_last) + k) % NREQ]) begin
                w_found = 1'b1;
                w_win   = IDXW'((int'(r_last) + k) % NREQ);
            end
        end
    end

    assign w_bad = ({1'b0, r_val} >= MOD_W);

    always_comb begin
        w_state_nxt = r_state;
        w_lde       = 1'b0;
        w_en        = 1'b0;
        w_ld        = '0;
        ld_err      = 1'b0;
        done        = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_lde       = 1'b1;
                w_ld        = w_bad ? '0 : r_val;
                ld_err      = w_bad;
                w_state_nxt = (r_len != '0) ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                w_en = 1'b1;
                if (r_rem == LENW'(1)) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done[r_widx] = 1'b1;
                w_state_nxt  = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_last  <= IDXW'(NREQ - 1);
            r_widx  <= '0;
            r_val   <= '0;
            r_len   <= '0;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_widx <= w_win;
                        r_val  <= ld_val[w_win*WIDTH +: WIDTH];
                        r_len  <= run_len[w_win*LENW +: LENW];
                    end
                end
                ST_LOAD: r_rem  <= r_len;
                ST_RUN:  r_rem  <= r_rem - 1'b1;
                ST_DONE: r_last <= r_widx;
                default: ;
            endcase
        end
    end

    always_comb begin
        gnt = '0;
        if (r_state != ST_IDLE) gnt[r_widx] = 1'b1;
    end

    assign busy    = (r_state != ST_IDLE);
    assign o_state = r_state;

    mod_count_core #(
        .WIDTH (WIDTH),
        .MOD   (MOD)
    ) u_core (
        .clk (clk),
        .rst (rst),
        .en  (w_en),
        .lde (w_lde),
        .ld  (w_ld),
        .Q   (Q)
    );

endmodule

// File: tb/tb_modcount_sched.sv
// Self-checking bench for modcount_sched: directed runs, wrap, bad load,
// round-robin contention, mid-run input changes, reset abort and random runs.
module tb_modcount_sched;
    import modcount_sched_pkg::*;

    localparam int WIDTH = 4;
    localparam int MOD   = 10;
    localparam int NREQ  = 2;
    localparam int LENW  = 8;
    localparam int EW    = NREQ + WIDTH;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] ld_val;
    logic [NREQ*LENW-1:0]  run_len;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic                  ld_err;
    logic [WIDTH-1:0]      Q;
    state_t                st;

    int n_checks = 0;
    int n_errors = 0;

    // Each entry is {done vector, final Q} for one expected completion.
    logic [EW-1:0] exp_q[$];

    modcount_sched #(
        .WIDTH (WIDTH),
        .MOD   (MOD),
        .NREQ  (NREQ),
        .LENW  (LENW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ld_val  (ld_val),
        .run_len (run_len),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .ld_err  (ld_err),
        .Q       (Q),
        .o_state (st)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst && gnt != '0) check("gnt_onehot", 32'($onehot(gnt)), 1);
        if (!rst && done != '0) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", done, 0);
            end else begin
                e = exp_q.pop_front();
                check("done_vec", done, e[WIDTH +: NREQ]);
                check("done_q", Q, e[WIDTH-1:0]);
            end
        end
    end

    task automatic push_exp(input int idx, input int q);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << idx;
        exp_q.push_back({oh, WIDTH'(q)});
    endtask

    // One full solo transaction, checked cycle by cycle from LOAD to IDLE.
    task automatic do_run(input int idx, input int v, input int len, input bit mess);
        int vld;
        logic [NREQ-1:0] oh;
        oh  = NREQ'(1) << idx;
        vld = (v >= MOD) ? 0 : v;
        ld_val[idx*WIDTH +: WIDTH] = WIDTH'(v);
        run_len[idx*LENW +: LENW]  = LENW'(len);
        req = oh;
        push_exp(idx, (vld + len) % MOD);
        @(negedge clk);
        check("load_gnt", gnt, oh);
        check("load_busy", busy, 1);
        check("load_err", ld_err, (v >= MOD) ? 1 : 0);
        check("load_state", st, ST_LOAD);
        if (!mess) req = '0;
        @(negedge clk);
        check("q_loaded", Q, vld);
        check("post_load_state", st, (len == 0) ? ST_DONE : ST_RUN);
        check("err_cleared", ld_err, 0);
        for (int k = 1; k <= len; k++) begin
            if (mess && k == 1) begin
                req     = '0;
                ld_val  = (NREQ*WIDTH)'($urandom);
                run_len = (NREQ*LENW)'($urandom);
            end
            @(negedge clk);
            check("q_run", Q, (vld + k) % MOD);
        end
        check("done_pulse", done, oh);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_gnt", gnt, 0);
        check("idle_done", done, 0);
        check("idle_q", Q, (vld + len) % MOD);
    endtask

    initial begin
        logic [NREQ-1:0] exp_g[3];
        logic [NREQ-1:0] prev_g;
        int ng;
        int ndone;

        rst = 1'b1;
        req = '0;
        ld_val = '0;
        run_len = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_q", Q, 0);
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", ld_err, 0);
        check("rst_state", st, ST_IDLE);
        @(negedge clk);
        check("idle_hold_q", Q, 0);

        do_run(0, 3, 4, 1'b0);
        do_run(0, 8, 5, 1'b0);
        do_run(0, 12, 0, 1'b0);
        do_run(0, 6, 7, 1'b1);
        do_run(1, 15, 1, 1'b0);
        do_run(0, 9, 255, 1'b0);

        // Last winner is 1 here, so requester 0 must be served first.
        do_run(1, 4, 2, 1'b0);
        ld_val  = {4'd7, 4'd2};
        run_len = {8'd6, 8'd3};
        req     = 2'b11;
        push_exp(0, 5);
        push_exp(1, 3);
        push_exp(0, 5);
        exp_g  = '{2'b01, 2'b10, 2'b01};
        prev_g = '0;
        ng     = 0;
        ndone  = 0;
        for (int c = 0; c < 100 && ndone < 3; c++) begin
            @(negedge clk);
            if (gnt != '0 && prev_g == '0) begin
                if (ng < 3) check("rr_gnt", gnt, exp_g[ng]);
                ng++;
            end
            prev_g = gnt;
            if (done != '0) ndone++;
        end
        req = '0;
        check("rr_done_count", ndone, 3);
        check("rr_grant_count", ng, 3);
        @(negedge clk);
        check("rr_idle_busy", busy, 0);

        // Abort a run with reset while Q=5; no done may follow.
        ld_val[0 +: WIDTH]  = 4'd2;
        run_len[0 +: LENW]  = 8'd8;
        req = 2'b01;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            req = '0;
            if (Q == 4'd5 && st == ST_RUN) break;
        end
        check("abort_at_q5", Q, 5);
        rst = 1'b1;
        @(negedge clk);
        check("abort_q", Q, 0);
        check("abort_gnt", gnt, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        rst = 1'b0;
        ld_val  = {4'd5, 4'd1};
        run_len = {8'd2, 8'd1};
        req = 2'b11;
        push_exp(0, 2);
        @(negedge clk);
        check("post_rst_gnt", gnt, 2'b01);
        req = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("post_rst_idle", busy, 0);

        for (int i = 0; i < 8; i++) begin
            do_run($urandom_range(0, NREQ-1), $urandom_range(0, 15),
                   $urandom_range(0, 12), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
